// File: rtl/quad_pkg.sv
// Shared types and Gray-code helpers for the quadrature decoder.
package quad_pkg;

    typedef enum logic {INIT, TRACK} quad_state_t;

    typedef enum logic [1:0] {
        STEP_NONE,
        STEP_FWD,
        STEP_REV,
        STEP_ILLEGAL
    } quad_step_t;

    // Forward Gray order on {a, b}: 00 -> 01 -> 11 -> 10 -> 00
    localparam logic [1:0] GRAY_0 = 2'b00;
    localparam logic [1:0] GRAY_1 = 2'b01;
    localparam logic [1:0] GRAY_2 = 2'b11;
    localparam logic [1:0] GRAY_3 = 2'b10;

    function automatic logic [1:0] gray_next(input logic [1:0] code);
        logic [1:0] nxt;
        nxt = GRAY_0;
        case (code)
            GRAY_0:  nxt = GRAY_1;
            GRAY_1:  nxt = GRAY_2;
            GRAY_2:  nxt = GRAY_3;
            default: nxt = GRAY_0;
        endcase
        return nxt;
    endfunction

    function automatic quad_step_t quad_step(input logic [1:0] prev, input logic [1:0] cur);
        quad_step_t s;
        if (cur == prev)
            s = STEP_NONE;
        else if (cur == gray_next(prev))
            s = STEP_FWD;
        else if (prev == gray_next(cur))
            s = STEP_REV;
        else
            s = STEP_ILLEGAL;
        return s;
    endfunction

endpackage

// File: rtl/quad_glitch_filter.sv
// Per-channel synchroniser followed by a persistence filter; during init the
// filter simply follows the synchronised level so tracking starts clean.
module quad_glitch_filter #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 3
) (
    input  logic clock,
    input  logic reset,
    input  logic init,
    input  logic pin,
    output logic filt
);

    localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync;
    logic [CW-1:0]          cnt;

    assign sync = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q <= '0;
            cnt    <= '0;
            filt   <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
            if (init) begin
                filt <= sync;
                cnt  <= '0;
            end else if (sync == filt) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                // Mismatch has now held for FILTER_LEN consecutive cycles
                filt <= sync;
                cnt  <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/quadrature_decoder.sv
// Quadrature A/B decoder: filtered channels, Gray-step decode, wrapped position
// and sticky illegal-transition flag. ready is a level status, not a handshake.
module quadrature_decoder
    import quad_pkg::*;
#(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             a_in,
    input  logic             b_in,
    input  logic             enable,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             clear_err,
    output logic             up,
    output logic             down,
    output logic             dir,
    output logic [WIDTH-1:0] position,
    output logic             error,
    output logic             ready,
    output quad_state_t      state
);

    localparam int INIT_LEN = SYNC_STAGES + FILTER_LEN;
    localparam int IW       = $clog2(INIT_LEN);
    localparam logic [IW-1:0] INIT_LAST = IW'(INIT_LEN - 1);

    quad_state_t      state_next;
    logic [IW-1:0]    init_cnt;
    logic             filt_a;
    logic             filt_b;
    logic [1:0]       filt_ab;
    logic [1:0]       prev;
    quad_step_t       step;
    logic             up_next;
    logic             down_next;
    logic             dir_next;
    logic [WIDTH-1:0] pos_next;
    logic             err_next;
    logic             in_init;

    assign in_init = (state == INIT);
    assign filt_ab = {filt_a, filt_b};
    assign step    = quad_step(prev, filt_ab);
    assign ready   = (state == TRACK);

    quad_glitch_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_filt_a (
        .clock (clock),
        .reset (reset),
        .init  (in_init),
        .pin   (a_in),
        .filt  (filt_a)
    );

    quad_glitch_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_filt_b (
        .clock (clock),
        .reset (reset),
        .init  (in_init),
        .pin   (b_in),
        .filt  (filt_b)
    );

    always_ff @(posedge clock) begin
        if (reset)
            state <= INIT;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        up_next    = 1'b0;
        down_next  = 1'b0;
        dir_next   = dir;
        pos_next   = position;
        err_next   = error;
        if (clear_err)
            err_next = 1'b0;
        case (state)
            INIT: begin
                if (init_cnt == INIT_LAST)
                    state_next = TRACK;
            end
            TRACK: begin
                // Illegal jumps are flagged even while disabled; a new jump beats clear_err
                case (step)
                    STEP_FWD: begin
                        if (enable) begin
                            up_next  = 1'b1;
                            dir_next = 1'b1;
                            pos_next = position + WIDTH'(1);
                        end
                    end
                    STEP_REV: begin
                        if (enable) begin
                            down_next = 1'b1;
                            dir_next  = 1'b0;
                            pos_next  = position - WIDTH'(1);
                        end
                    end
                    STEP_ILLEGAL: err_next = 1'b1;
                    default: ;
                endcase
            end
            default: state_next = INIT;
        endcase
        if (load)
            pos_next = load_value;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            init_cnt <= '0;
            prev     <= 2'b00;
            up       <= 1'b0;
            down     <= 1'b0;
            dir      <= 1'b1;
            position <= '0;
            error    <= 1'b0;
        end else begin
            init_cnt <= in_init ? init_cnt + IW'(1) : '0;
            prev     <= filt_ab;
            up       <= up_next;
            down     <= down_next;
            dir      <= dir_next;
            position <= pos_next;
            error    <= err_next;
        end
    end

endmodule

// File: tb/tb_quadrature_decoder.sv
// Directed bench for quadrature_decoder: inputs driven and outputs sampled on
// the falling clock edge, expected values worked out by hand.
module tb_quadrature_decoder;
    import quad_pkg::*;

    logic        clock;
    logic        reset;
    logic        a_in;
    logic        b_in;
    logic        enable;
    logic        load;
    logic [3:0]  load_value;
    logic        clear_err;
    logic        up;
    logic        down;
    logic        dir;
    logic [3:0]  position;
    logic        error;
    logic        ready;
    quad_state_t state;

    int checks;
    int errors;
    int both_hi;

    quadrature_decoder dut (
        .clock      (clock),
        .reset      (reset),
        .a_in       (a_in),
        .b_in       (b_in),
        .enable     (enable),
        .load       (load),
        .load_value (load_value),
        .clear_err  (clear_err),
        .up         (up),
        .down       (down),
        .dir        (dir),
        .position   (position),
        .error      (error),
        .ready      (ready),
        .state      (state)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

    // driver: set pins at a falling edge, then observe for a number of cycles
    task automatic phase(input logic a, input logic b, input int cycles,
                         output int ups, output int downs, output int first_up);
        a_in = a;
        b_in = b;
        ups = 0;
        downs = 0;
        first_up = 0;
        for (int k = 1; k <= cycles; k++) begin
            @(negedge clock);
            if (up) begin
                ups++;
                if (first_up == 0) first_up = k;
            end
            if (down) downs++;
            if (up && down) both_hi++;
        end
    endtask

    task automatic test_reset;
        int rdy_k;
        reset = 1'b1;
        a_in = 1'b0;
        b_in = 1'b0;
        enable = 1'b1;
        load = 1'b0;
        load_value = 4'h0;
        clear_err = 1'b0;
        repeat (3) @(negedge clock);
        checks++; if (up !== 1'b0) begin errors++; $display("FAIL reset_up got %b expected 0", up); end
        checks++; if (down !== 1'b0) begin errors++; $display("FAIL reset_down got %b expected 0", down); end
        checks++; if (dir !== 1'b1) begin errors++; $display("FAIL reset_dir got %b expected 1", dir); end
        checks++; if (position !== 4'h0) begin errors++; $display("FAIL reset_position got %h expected 0", position); end
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL reset_error got %b expected 0", error); end
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b expected 0", ready); end
        checks++; if (state !== INIT) begin errors++; $display("FAIL reset_state got %0d expected INIT", state); end
        reset = 1'b0;
        rdy_k = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clock);
            if (ready && rdy_k == 0) rdy_k = k;
        end
        checks++; if (rdy_k !== 5) begin errors++; $display("FAIL reset_ready_latency got %0d expected 5", rdy_k); end
    endtask

    task automatic test_forward;
        logic [1:0] seq [4];
        int ups, downs, first_up;
        seq = '{2'b01, 2'b11, 2'b10, 2'b00};
        for (int i = 0; i < 4; i++) begin
            phase(seq[i][1], seq[i][0], 10, ups, downs, first_up);
            checks++; if (ups !== 1) begin errors++; $display("FAIL fwd_up_count phase %0d got %0d expected 1", i, ups); end
            checks++; if (first_up !== 6) begin errors++; $display("FAIL fwd_latency phase %0d got %0d expected 6", i, first_up); end
            checks++; if (downs !== 0) begin errors++; $display("FAIL fwd_down_count phase %0d got %0d expected 0", i, downs); end
        end
        checks++; if (position !== 4'h4) begin errors++; $display("FAIL fwd_position got %h expected 4", position); end
        checks++; if (dir !== 1'b1) begin errors++; $display("FAIL fwd_dir got %b expected 1", dir); end
    endtask

    task automatic test_wrap;
        int ups, downs, first_up;
        load = 1'b1;
        load_value = 4'hF;
        @(negedge clock);
        load = 1'b0;
        checks++; if (position !== 4'hF) begin errors++; $display("FAIL wrap_load got %h expected f", position); end
        phase(1'b0, 1'b1, 10, ups, downs, first_up);
        checks++; if (ups !== 1) begin errors++; $display("FAIL wrap_up_count got %0d expected 1", ups); end
        checks++; if (position !== 4'h0) begin errors++; $display("FAIL wrap_up_position got %h expected 0", position); end
        load = 1'b1;
        load_value = 4'h0;
        @(negedge clock);
        load = 1'b0;
        phase(1'b0, 1'b0, 10, ups, downs, first_up);
        checks++; if (downs !== 1 || ups !== 0) begin errors++; $display("FAIL wrap_down_count got down %0d up %0d expected 1/0", downs, ups); end
        checks++; if (position !== 4'hF) begin errors++; $display("FAIL wrap_down_position got %h expected f", position); end
        checks++; if (dir !== 1'b0) begin errors++; $display("FAIL wrap_down_dir got %b expected 0", dir); end
    endtask

    task automatic test_glitch;
        int ups, downs, first_up, tu, td;
        phase(1'b1, 1'b0, 2, ups, downs, first_up);
        tu = ups; td = downs;
        phase(1'b0, 1'b0, 10, ups, downs, first_up);
        tu += ups; td += downs;
        checks++; if (tu !== 0 || td !== 0) begin errors++; $display("FAIL glitch2_pulses got up %0d down %0d expected 0/0", tu, td); end
        checks++; if (position !== 4'hF) begin errors++; $display("FAIL glitch2_position got %h expected f", position); end
        // 3-cycle pulse is accepted: 00->10 is a reverse step, 10->00 forward
        phase(1'b1, 1'b0, 3, ups, downs, first_up);
        tu = ups; td = downs;
        phase(1'b0, 1'b0, 12, ups, downs, first_up);
        tu += ups; td += downs;
        checks++; if (tu !== 1 || td !== 1) begin errors++; $display("FAIL glitch3_pulses got up %0d down %0d expected 1/1", tu, td); end
        checks++; if (position !== 4'hF) begin errors++; $display("FAIL glitch3_position got %h expected f", position); end
    endtask

    task automatic test_error;
        int ups, downs, first_up;
        logic err_early;
        logic err_k6;
        phase(1'b1, 1'b1, 10, ups, downs, first_up);
        checks++; if (error !== 1'b1) begin errors++; $display("FAIL err_set got %b expected 1", error); end
        checks++; if (ups !== 0 || downs !== 0) begin errors++; $display("FAIL err_no_pulse got up %0d down %0d expected 0/0", ups, downs); end
        checks++; if (position !== 4'hF) begin errors++; $display("FAIL err_position got %h expected f", position); end
        clear_err = 1'b1;
        @(negedge clock);
        clear_err = 1'b0;
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL err_clear got %b expected 0", error); end
        a_in = 1'b0;
        b_in = 1'b0;
        err_early = 1'b0;
        err_k6 = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clock);
            if (k <= 5 && error) err_early = 1'b1;
            if (k == 6) err_k6 = error;
            clear_err = (k == 5);
        end
        checks++; if (err_early !== 1'b0) begin errors++; $display("FAIL err_early got %b expected 0", err_early); end
        checks++; if (err_k6 !== 1'b1) begin errors++; $display("FAIL err_clear_collision got %b expected 1", err_k6); end
        clear_err = 1'b1;
        @(negedge clock);
        clear_err = 1'b0;
    endtask

    task automatic test_enable;
        int ups, downs, first_up, tu, td;
        enable = 1'b0;
        phase(1'b0, 1'b1, 10, ups, downs, first_up);
        tu = ups; td = downs;
        phase(1'b1, 1'b1, 10, ups, downs, first_up);
        tu += ups; td += downs;
        phase(1'b1, 1'b0, 10, ups, downs, first_up);
        tu += ups; td += downs;
        enable = 1'b1;
        phase(1'b1, 1'b0, 10, ups, downs, first_up);
        tu += ups; td += downs;
        checks++; if (tu !== 0 || td !== 0) begin errors++; $display("FAIL enable_off_pulses got up %0d down %0d expected 0/0", tu, td); end
        checks++; if (position !== 4'hF) begin errors++; $display("FAIL enable_off_position got %h expected f", position); end
        phase(1'b0, 1'b0, 10, ups, downs, first_up);
        checks++; if (ups !== 1 || downs !== 0) begin errors++; $display("FAIL enable_on_pulses got up %0d down %0d expected 1/0", ups, downs); end
        checks++; if (position !== 4'h0) begin errors++; $display("FAIL enable_on_position got %h expected 0", position); end
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL enable_error got %b expected 0", error); end
    endtask

    task automatic test_load_step;
        int ups, first_up;
        logic [3:0] pos_k6;
        a_in = 1'b0;
        b_in = 1'b1;
        ups = 0;
        first_up = 0;
        pos_k6 = 4'h0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clock);
            if (up) begin
                ups++;
                if (first_up == 0) first_up = k;
            end
            if (k == 6) pos_k6 = position;
            load = (k == 5);
            load_value = 4'h5;
        end
        checks++; if (ups !== 1 || first_up !== 6) begin errors++; $display("FAIL load_step_pulse got count %0d at %0d expected 1 at 6", ups, first_up); end
        checks++; if (pos_k6 !== 4'h5) begin errors++; $display("FAIL load_step_position got %h expected 5", pos_k6); end
        checks++; if (dir !== 1'b1) begin errors++; $display("FAIL load_step_dir got %b expected 1", dir); end
    endtask

    task automatic test_reset_mid;
        int ups, downs, first_up, rdy_k;
        a_in = 1'b1;
        b_in = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        checks++; if (up !== 1'b0 || down !== 1'b0) begin errors++; $display("FAIL mid_reset_pulses got %b%b expected 00", up, down); end
        checks++; if (dir !== 1'b1) begin errors++; $display("FAIL mid_reset_dir got %b expected 1", dir); end
        checks++; if (position !== 4'h0) begin errors++; $display("FAIL mid_reset_position got %h expected 0", position); end
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL mid_reset_error got %b expected 0", error); end
        checks++; if (ready !== 1'b0 || state !== INIT) begin errors++; $display("FAIL mid_reset_ready got %b state %0d expected 0 INIT", ready, state); end
        reset = 1'b0;
        rdy_k = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clock);
            if (ready && rdy_k == 0) rdy_k = k;
        end
        checks++; if (rdy_k !== 5) begin errors++; $display("FAIL mid_reset_ready_latency got %0d expected 5", rdy_k); end
        phase(1'b1, 1'b1, 10, ups, downs, first_up);
        checks++; if (ups !== 0 || downs !== 0 || position !== 4'h0) begin errors++; $display("FAIL mid_reset_quiet got up %0d down %0d pos %h expected 0/0/0", ups, downs, position); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        both_hi = 0;
        test_reset();
        test_forward();
        test_wrap();
        test_glitch();
        test_error();
        test_enable();
        test_load_step();
        test_reset_mid();
        checks++; if (both_hi !== 0) begin errors++; $display("FAIL up_down_exclusive got %0d overlaps expected 0", both_hi); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
